// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the 4-stage pipeline sequencing controller.
//   - opcode encodings of the instruction set (5-bit)
//   - bit positions inside the 8-bit decoder control word
//   - NOP control word and the controller state type
//   - helpers telling which register operands an opcode reads
package pipe_ctrl_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_MOVI = 5'b00011;
  localparam logic [4:0] OP_LODR = 5'b00100;
  localparam logic [4:0] OP_STOR = 5'b00101;
  localparam logic [4:0] OP_JMP  = 5'b00110;
  localparam logic [4:0] OP_JEQ  = 5'b00111;

  localparam int unsigned CTL_MEMREAD  = 7;
  localparam int unsigned CTL_MEMWRITE = 6;
  localparam int unsigned CTL_JEQ      = 4;
  localparam int unsigned CTL_JMP      = 3;
  localparam int unsigned CTL_REGWRITE = 0;

  localparam logic [7:0] CTL_NOP = 8'b00000010;

  typedef enum logic [0:0] {
    RUN,
    MEM_WAIT
  } state_e;

  // Undefined opcodes read no registers, so they can never cause a stall.
  function automatic logic op_uses_rs(input logic [4:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_LODR, OP_STOR, OP_JEQ: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_uses_rt(input logic [4:0] op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_STOR, OP_JEQ: r = 1'b1;
      default:                         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count this cycle
//   cnt   : current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the IF/ID/EX/WB in-order pipeline.
// Inputs : id_opcode/id_rs/id_rt (ID operands), ex_controls/ex_rd/ex_zero (EX instruction),
//          mem_ready (shared memory finished the data access this cycle).
// Outputs: pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, wb_bubble, pc_sel_branch,
//          dmem_sel (memory port owner), mem_err (sticky timeout), stall_cnt, flush_cnt.
// No forwarding: a RegWrite in EX whose destination is read in ID costs one bubble;
// register file write-through covers the WB-to-ID distance.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [7:0]        ex_controls,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_zero,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              ex_hold,
  output logic              wb_bubble,
  output logic              pc_sel_branch,
  output logic              dmem_sel,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned      WCW       = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCW-1:0]   WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
  localparam logic [WCW-1:0]   WAIT_ONE  = WCW'(1);

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           mem_err_q, mem_err_d;

  logic mem_op, taken, raw;
  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_bubble_c;
  logic ex_hold_c, wb_bubble_c, pc_sel_c, dmem_sel_c, flush_evt;

  logic unused_ctl;
  assign unused_ctl = ^{ex_controls[5], ex_controls[2:1]};

  assign mem_op = ex_controls[CTL_MEMREAD] | ex_controls[CTL_MEMWRITE];
  assign taken  = ex_controls[CTL_JMP] | (ex_controls[CTL_JEQ] & ex_zero);
  assign raw    = ex_controls[CTL_REGWRITE] &
                  ((op_uses_rs(id_opcode) & (id_rs == ex_rd)) |
                   (op_uses_rt(id_opcode) & (id_rt == ex_rd)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = mem_err_q;
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    ex_hold_c     = 1'b0;
    wb_bubble_c   = 1'b0;
    pc_sel_c      = 1'b0;
    dmem_sel_c    = 1'b0;
    flush_evt     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (taken) begin
          // Flush beats any hazard: the ID instruction is discarded anyway.
          pc_sel_c      = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          flush_evt     = 1'b1;
        end else if (mem_op) begin
          dmem_sel_c = 1'b1;
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          if (mem_ready) begin
            idex_bubble_c = 1'b1;
          end else begin
            ex_hold_c   = 1'b1;
            wb_bubble_c = 1'b1;
            wait_cnt_d  = WAIT_ONE;
            state_d     = MEM_WAIT;
          end
        end else if (raw) begin
          pc_en_c       = 1'b0;
          ifid_en_c     = 1'b0;
          idex_bubble_c = 1'b1;
        end
      end

      MEM_WAIT: begin
        dmem_sel_c = 1'b1;
        pc_en_c    = 1'b0;
        ifid_en_c  = 1'b0;
        if (mem_ready || (wait_cnt_q == WAIT_LAST)) begin
          // A timeout releases the pipeline exactly like a completed access.
          idex_bubble_c = 1'b1;
          state_d       = RUN;
          if (!mem_ready) begin
            mem_err_d = 1'b1;
          end
        end else begin
          ex_hold_c   = 1'b1;
          wb_bubble_c = 1'b1;
          wait_cnt_d  = wait_cnt_q + WAIT_ONE;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // While in reset the pipeline is held with NOPs in IF/ID and ID/EX.
  assign pc_en         = rst_n & pc_en_c;
  assign ifid_en       = rst_n & ifid_en_c;
  assign ifid_flush    = ~rst_n | ifid_flush_c;
  assign idex_bubble   = ~rst_n | idex_bubble_c;
  assign ex_hold       = rst_n & ex_hold_c;
  assign wb_bubble     = rst_n & wb_bubble_c;
  assign pc_sel_branch = rst_n & pc_sel_c;
  assign dmem_sel      = rst_n & dmem_sel_c;
  assign mem_err       = mem_err_q;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_en_c),
    .cnt   (stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_evt),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors with literal expectations, plus a
// cycle-level reference model compared against every output on each falling clock edge.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned REG_AW      = 3;
  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 16;
  localparam int          CMAX        = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4:0]        id_opcode;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
  logic [7:0]        ex_controls;
  logic              ex_zero, mem_ready;
  logic              pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, wb_bubble;
  logic              pc_sel_branch, dmem_sel, mem_err;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(
    .REG_AW      (REG_AW),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_opcode     (id_opcode),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_controls   (ex_controls),
    .ex_rd         (ex_rd),
    .ex_zero       (ex_zero),
    .mem_ready     (mem_ready),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .ex_hold       (ex_hold),
    .wb_bubble     (wb_bubble),
    .pc_sel_branch (pc_sel_branch),
    .dmem_sel      (dmem_sel),
    .mem_err       (mem_err),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, wb_bubble, pc_sel, dmem_sel;
  } outs_t;

  bit m_waiting;   // a data access is outstanding
  int m_waited;    // stalled cycles already spent on it
  bit m_err;
  int m_stall, m_flush;

  function automatic bit reads_rs(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_LODR, OP_STOR, OP_JEQ};
  endfunction

  function automatic bit reads_rt(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_STOR, OP_JEQ};
  endfunction

  function automatic outs_t expect_outs();
    outs_t e;
    bit memop, tk, hz;
    e = '0;
    if (!rst_n) begin
      e.ifid_flush  = 1'b1;
      e.idex_bubble = 1'b1;
      return e;
    end
    e.pc_en   = 1'b1;
    e.ifid_en = 1'b1;
    memop = ex_controls[7] || ex_controls[6];
    tk    = ex_controls[3] || (ex_controls[4] && ex_zero);
    hz    = ex_controls[0] && ((reads_rs(id_opcode) && id_rs == ex_rd) ||
                               (reads_rt(id_opcode) && id_rt == ex_rd));
    if (m_waiting || (!tk && memop)) begin
      e.pc_en    = 1'b0;
      e.ifid_en  = 1'b0;
      e.dmem_sel = 1'b1;
      // Released on ready, or on the access's MEM_TIMEOUT-th stalled cycle.
      if (mem_ready || (m_waiting && m_waited == MEM_TIMEOUT - 1)) begin
        e.idex_bubble = 1'b1;
      end else begin
        e.ex_hold   = 1'b1;
        e.wb_bubble = 1'b1;
      end
    end else if (tk) begin
      e.pc_sel      = 1'b1;
      e.ifid_flush  = 1'b1;
      e.idex_bubble = 1'b1;
    end else if (hz) begin
      e.pc_en       = 1'b0;
      e.ifid_en     = 1'b0;
      e.idex_bubble = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    outs_t e;
    if (!rst_n) begin
      m_waiting <= 1'b0;
      m_waited  <= 0;
      m_err     <= 1'b0;
      m_stall   <= 0;
      m_flush   <= 0;
    end else begin
      e = expect_outs();
      if (!e.pc_en && m_stall < CMAX) m_stall <= m_stall + 1;
      if (e.pc_sel && m_flush < CMAX) m_flush <= m_flush + 1;
      if (m_waiting) begin
        if (!e.ex_hold) begin
          m_waiting <= 1'b0;
          if (!mem_ready) m_err <= 1'b1;
        end else begin
          m_waited <= m_waited + 1;
        end
      end else if (e.ex_hold) begin
        m_waiting <= 1'b1;
        m_waited  <= 1;
      end
    end
  end

  always @(negedge clk) begin
    outs_t e;
    e = expect_outs();
    chk("pc_en",         int'(pc_en),         int'(e.pc_en));
    chk("ifid_en",       int'(ifid_en),       int'(e.ifid_en));
    chk("ifid_flush",    int'(ifid_flush),    int'(e.ifid_flush));
    chk("idex_bubble",   int'(idex_bubble),   int'(e.idex_bubble));
    chk("ex_hold",       int'(ex_hold),       int'(e.ex_hold));
    chk("wb_bubble",     int'(wb_bubble),     int'(e.wb_bubble));
    chk("pc_sel_branch", int'(pc_sel_branch), int'(e.pc_sel));
    chk("dmem_sel",      int'(dmem_sel),      int'(e.dmem_sel));
    chk("mem_err",       int'(mem_err),       int'(m_err));
    chk("stall_cnt",     int'(stall_cnt),     m_stall);
    chk("flush_cnt",     int'(flush_cnt),     m_flush);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_nop();
    ex_controls = CTL_NOP;
    ex_zero     = 1'b0;
    mem_ready   = 1'b0;
    id_opcode   = OP_NOP;
  endtask

  initial begin
    int nlow;
    rst_n = 1'b0;
    ex_rd = '0;
    id_rs = '0;
    id_rt = '0;
    ex_nop();
    repeat (2) @(negedge clk);
    chk("reset pc_en",       int'(pc_en),       0);
    chk("reset ifid_flush",  int'(ifid_flush),  1);
    chk("reset idex_bubble", int'(idex_bubble), 1);
    chk("reset stall_cnt",   int'(stall_cnt),   0);
    chk("reset flush_cnt",   int'(flush_cnt),   0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("release pc_en",       int'(pc_en),       1);
    chk("release idex_bubble", int'(idex_bubble), 0);

    // RAW: ADD writing r3 in EX, SUB reading r3 in ID
    cyc();
    ex_controls = 8'b00100011; ex_rd = 3'd3; id_opcode = OP_SUB; id_rs = 3'd3; id_rt = 3'd5;
    @(negedge clk);
    chk("raw pc_en",       int'(pc_en),       0);
    chk("raw idex_bubble", int'(idex_bubble), 1);
    cyc();
    ex_nop();
    @(negedge clk);
    chk("raw one bubble pc_en", int'(pc_en),     1);
    chk("raw stall_cnt",        int'(stall_cnt), 1);

    // MOVI reads nothing
    cyc();
    ex_controls = 8'b00100011; id_opcode = OP_MOVI;
    @(negedge clk);
    chk("movi pc_en", int'(pc_en), 1);

    // Taken JEQ with a coincident RAW match: flush only
    cyc();
    ex_controls = 8'b00010001; ex_zero = 1'b1; id_opcode = OP_SUB;
    @(negedge clk);
    chk("jeq taken pc_sel",     int'(pc_sel_branch), 1);
    chk("jeq taken ifid_flush", int'(ifid_flush),    1);
    chk("jeq taken pc_en",      int'(pc_en),         1);
    cyc();
    ex_controls = 8'b00010000; ex_zero = 1'b0;
    @(negedge clk);
    chk("jeq not taken pc_sel", int'(pc_sel_branch), 0);
    chk("jeq not taken flush",  int'(ifid_flush),    0);
    chk("flush_cnt after jeq",  int'(flush_cnt),     1);
    chk("stall_cnt after jeq",  int'(stall_cnt),     1);

    // Load with three not-ready cycles
    cyc();
    ex_nop();
    ex_controls = 8'b10000001; ex_rd = 3'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("load ex_hold", int'(ex_hold), 1);
      cyc();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("load release ex_hold",     int'(ex_hold),     0);
    chk("load release idex_bubble", int'(idex_bubble), 1);
    chk("load release pc_en",       int'(pc_en),       0);
    cyc();
    ex_nop();
    @(negedge clk);
    chk("after load pc_en",    int'(pc_en),     1);
    chk("after load dmem_sel", int'(dmem_sel),  0);
    chk("after load stall",    int'(stall_cnt), 5);

    // Store that never completes
    cyc();
    ex_controls = 8'b01000000;
    nlow = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!pc_en) nlow++;
      if (i == 15) chk("timeout release ex_hold", int'(ex_hold), 0);
      cyc();
    end
    ex_nop();
    @(negedge clk);
    chk("timeout stalled cycles", nlow,             16);
    chk("timeout mem_err",        int'(mem_err),    1);
    chk("timeout next pc_en",     int'(pc_en),      1);
    chk("timeout stall_cnt",      int'(stall_cnt),  21);

    // Reset in the middle of a wait
    cyc();
    ex_controls = 8'b10000001;
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("midwait mem_err",   int'(mem_err),   0);
    chk("midwait stall_cnt", int'(stall_cnt), 0);
    chk("midwait flush_cnt", int'(flush_cnt), 0);
    chk("midwait ex_hold",   int'(ex_hold),   0);
    cyc();
    rst_n = 1'b1;
    ex_nop();
    @(negedge clk);
    chk("midwait run pc_en",    int'(pc_en),    1);
    chk("midwait run dmem_sel", int'(dmem_sel), 0);

    // Both memory bits set, ready at once: single stall cycle
    cyc();
    ex_controls = 8'b11000000; mem_ready = 1'b1;
    @(negedge clk);
    chk("dual mem pc_en",   int'(pc_en),   0);
    chk("dual mem ex_hold", int'(ex_hold), 0);
    cyc();
    ex_controls = CTL_NOP;
    @(negedge clk);
    chk("stray ready pc_en",    int'(pc_en),    1);
    chk("stray ready dmem_sel", int'(dmem_sel), 0);

    // Operand-usage sweep, including an undefined opcode, checked by the model
    for (int op = 0; op < 9; op++) begin
      for (int side = 0; side < 2; side++) begin
        cyc();
        ex_controls = 8'b00100011; ex_rd = 3'd2; mem_ready = 1'b0;
        id_opcode   = (op == 8) ? 5'b10101 : 5'(op);
        id_rs       = (side == 0) ? 3'd2 : 3'd4;
        id_rt       = (side == 0) ? 3'd4 : 3'd2;
        cyc();
        ex_nop();
      end
    end
    cyc();
    ex_controls = 8'b00001000;
    cyc();
    ex_nop();
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
